// File: rtl/fwd_hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX operand forwarding selects,
// load-use stall, branch flush, pipeline freeze and a stall-cycle counter.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_busy_i,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    // The MEM/WB shadow is never a comparison source: by the time the consumer
    // sits in EX its data comes from EX/MEM or MEM/WB, both captured one stage earlier.
    logic                  ex_valid_q, ex_regwrite_q, ex_memread_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  mem_valid_q, mem_regwrite_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  ex_valid_d, ex_regwrite_d, ex_memread_d;
    logic [REG_ADDR_W-1:0] ex_rd_d;

    logic [1:0][1:0]       fwd_sel_q;
    logic [1:0][1:0]       fwd_sel_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic                  load_use;
    logic                  bubble;
    logic [1:0][REG_ADDR_W-1:0] src_reg;
    logic [1:0]            src_en;
    logic [1:0]            hit_ex, hit_mem;

    assign src_reg[0] = id_rs_i;
    assign src_en[0]  = 1'b1;
    assign src_reg[1] = id_rt_i;
    assign src_en[1]  = id_uses_rt_i;

    assign load_use = id_valid_i & ex_valid_q & ex_memread_q & (ex_rd_q != '0) &
                      ((ex_rd_q == id_rs_i) | (id_uses_rt_i & (ex_rd_q == id_rt_i)));
    assign bubble   = branch_taken_i | load_use;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign hit_ex[gi]  = src_en[gi] & ex_valid_q & ex_regwrite_q &
                                 (ex_rd_q != '0) & (ex_rd_q == src_reg[gi]);
            assign hit_mem[gi] = src_en[gi] & mem_valid_q & mem_regwrite_q &
                                 (mem_rd_q != '0) & (mem_rd_q == src_reg[gi]);
            // Youngest producer wins; a bubble entering EX never forwards.
            assign fwd_sel_d[gi] = bubble      ? SEL_RF  :
                                   hit_ex[gi]  ? SEL_ALU :
                                   hit_mem[gi] ? SEL_WB  : SEL_RF;
        end
    endgenerate

    always_comb begin
        ex_valid_d    = id_valid_i;
        ex_regwrite_d = id_regwrite_i;
        ex_memread_d  = id_memread_i;
        ex_rd_d       = id_rd_i;
        if (bubble) begin
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use && !branch_taken_i && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
            fwd_sel_q      <= '0;
            stall_cnt_q    <= '0;
        end else if (!mem_busy_i) begin
            ex_valid_q     <= ex_valid_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_rd_q        <= ex_rd_d;
            mem_valid_q    <= ex_valid_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_rd_q       <= ex_rd_q;
            fwd_sel_q      <= fwd_sel_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        if (rst_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (mem_busy_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end
    end

    assign fwd_a_sel_o = fwd_sel_q[0];
    assign fwd_b_sel_o = fwd_sel_q[1];
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized and directed bench for fwd_hazard_ctrl against an in-flight
// instruction list model; a second instance uses a 2-bit counter for saturation.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_uses_rt, id_regwrite, id_memread, branch_taken, mem_busy;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] sel_a, sel_b, sel_a2, sel_b2;
    logic       pc_write, ifid_write, ifid_flush, idex_flush;
    logic       pc_write2, ifid_write2, ifid_flush2, idex_flush2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
        .id_memread_i(id_memread), .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
        .fwd_a_sel_o(sel_a), .fwd_b_sel_o(sel_b), .pc_write_o(pc_write),
        .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
        .stall_cnt_o(cnt)
    );

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
        .id_memread_i(id_memread), .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
        .fwd_a_sel_o(sel_a2), .fwd_b_sel_o(sel_b2), .pc_write_o(pc_write2),
        .ifid_write_o(ifid_write2), .ifid_flush_o(ifid_flush2), .idex_flush_o(idex_flush2),
        .stall_cnt_o(cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: instructions that have left ID, youngest first (only two matter).
    typedef struct {
        bit       v;
        bit       rw;
        bit       mr;
        bit [4:0] rd;
    } instr_t;

    instr_t flight[$];
    bit       known = 0;
    bit [1:0] m_sel_a, m_sel_b;
    int       m_cnt, m_cnt2;

    function automatic bit [1:0] pick(input bit [4:0] src, input bit en);
        if (!en) return 2'b00;
        for (int k = 0; k < 2; k++)
            if (flight[k].v && flight[k].rw && flight[k].rd != 0 && flight[k].rd == src)
                return (k == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        bit lu;
        bit [3:0] e;   // {pc_write, ifid_write, ifid_flush, idex_flush}
        instr_t ni;
        lu = 0;
        if (known)
            lu = id_valid && flight[0].v && flight[0].mr && flight[0].rd != 0 &&
                 (flight[0].rd == id_rs || (id_uses_rt && flight[0].rd == id_rt));
        if (rst)               e = 4'b0011;
        else if (mem_busy)     e = 4'b0000;
        else if (branch_taken) e = 4'b1111;
        else if (lu)           e = 4'b0001;
        else                   e = 4'b1100;
        if (known || rst) begin
            chk("cmp_pc_write",   pc_write,   e[3]);
            chk("cmp_ifid_write", ifid_write, e[2]);
            chk("cmp_ifid_flush", ifid_flush, e[1]);
            chk("cmp_idex_flush", idex_flush, e[0]);
            chk("cmp_sat_enables", {pc_write2, ifid_write2, ifid_flush2, idex_flush2}, e);
        end
        if (known) begin
            chk("cmp_sel_a", sel_a, m_sel_a);
            chk("cmp_sel_b", sel_b, m_sel_b);
            chk("cmp_sat_sels", {sel_a2, sel_b2}, {m_sel_a, m_sel_b});
            chk("cmp_cnt",   cnt,   m_cnt);
            chk("cmp_cnt2",  cnt2,  m_cnt2);
        end
        if (rst) begin
            flight.delete();
            ni = '{v: 0, rw: 0, mr: 0, rd: 0};
            flight.push_back(ni);
            flight.push_back(ni);
            m_sel_a = 0; m_sel_b = 0; m_cnt = 0; m_cnt2 = 0;
            known = 1;
        end else if (known && !mem_busy) begin
            if (branch_taken || lu) begin
                m_sel_a = 0; m_sel_b = 0;
                ni = '{v: 0, rw: 0, mr: 0, rd: id_rd};
            end else begin
                m_sel_a = pick(id_rs, 1'b1);
                m_sel_b = pick(id_rt, id_uses_rt);
                ni = '{v: id_valid, rw: id_regwrite, mr: id_memread, rd: id_rd};
            end
            if (lu && !branch_taken) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            flight.push_front(ni);
            void'(flight.pop_back());
        end
    end

    task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit ut,
                          input bit [4:0] rd, input bit rw, input bit mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
        branch_taken = 0; mem_busy = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit [4:0] rs, input bit [4:0] rt, input bit ut,
                         input bit [4:0] rd, input bit rw, input bit mr);
        set_id(1, rs, rt, ut, rd, rw, mr);
        step();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            set_id(0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    initial begin
        rst = 1;
        set_id(0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 0;
        chk("reset_sel_a", sel_a, 2'b00);
        chk("reset_cnt", cnt, 0);
        #1 chk("after_reset_pc_write", pc_write, 1);

        // ALU forward at distance 1, 2, 3
        issue(1, 2, 1, 3, 1, 0);
        issue(3, 4, 1, 6, 1, 0);
        chk("alu_fwd_dist1", sel_a, 2'b10);
        nops(3);
        issue(1, 2, 1, 3, 1, 0);
        issue(8, 9, 1, 7, 1, 0);
        issue(3, 4, 1, 6, 1, 0);
        chk("alu_fwd_dist2", sel_a, 2'b01);
        nops(3);
        issue(1, 2, 1, 3, 1, 0);
        issue(8, 9, 1, 7, 1, 0);
        issue(8, 9, 1, 7, 1, 0);
        issue(3, 4, 1, 6, 1, 0);
        chk("alu_fwd_dist3", sel_a, 2'b00);
        nops(3);

        // register 0 is never forwarded
        issue(1, 2, 1, 0, 1, 0);
        issue(0, 0, 1, 6, 1, 0);
        chk("r0_sel_a", sel_a, 2'b00);
        chk("r0_sel_b", sel_b, 2'b00);
        nops(3);

        // load-use stall on rt
        issue(1, 2, 1, 5, 1, 1);
        set_id(1, 1, 5, 1, 8, 1, 0);
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_idex_flush", idex_flush, 1);
        chk("lu_cnt_before", cnt, 0);
        step();
        chk("lu_cnt_after", cnt, 1);
        chk("lu_released", pc_write, 1);
        step();
        chk("lu_fwd_b", sel_b, 2'b01);
        nops(3);

        // branch coincident with load-use
        issue(1, 2, 1, 10, 1, 1);
        set_id(1, 10, 0, 0, 8, 1, 0);
        branch_taken = 1;
        #1;
        chk("br_ifid_flush", ifid_flush, 1);
        chk("br_idex_flush", idex_flush, 1);
        chk("br_pc_write", pc_write, 1);
        step();
        chk("br_cnt_hold", cnt, 1);
        nops(3);

        // freeze over a pending load-use
        issue(1, 2, 1, 11, 1, 1);
        set_id(1, 11, 0, 0, 8, 1, 0);
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1;
            #1;
            chk("frz_enables", {pc_write, ifid_write, ifid_flush, idex_flush}, 4'b0000);
            chk("frz_cnt", cnt, 1);
            step();
        end
        mem_busy = 0;
        #1;
        chk("frz_release_stall", {pc_write, idex_flush}, 2'b01);
        step();
        chk("frz_cnt_after", cnt, 2);
        step();
        chk("frz_fwd_a", sel_a, 2'b01);
        nops(3);

        // reset in the middle of a stall
        issue(1, 2, 1, 12, 1, 1);
        set_id(1, 12, 0, 0, 8, 1, 0);
        #1 chk("rst_pre_stall", idex_flush, 1);
        rst = 1;
        #1 chk("rst_enables", {pc_write, ifid_write, ifid_flush, idex_flush}, 4'b0011);
        step();
        chk("rst_cnt", cnt, 0);
        chk("rst_sels", {sel_a, sel_b}, 4'b0000);
        rst = 0;
        #1 chk("rst_no_stale_lu", {pc_write, idex_flush}, 2'b10);
        step();
        chk("rst_no_stale_fwd", sel_a, 2'b00);
        nops(2);

        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            issue(1, 2, 1, 5, 1, 1);
            set_id(1, 5, 0, 0, 9, 1, 0);
            step(); step();
            nops(1);
        end
        chk("sat_cnt2", cnt2, 3);
        chk("sat_cnt16", cnt, 5);

        // random traffic over a small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            id_valid     = ($urandom_range(0, 9) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            id_rd        = 5'($urandom_range(0, 3));
            id_regwrite  = ($urandom_range(0, 3) != 0);
            id_memread   = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 6) == 0);
            mem_busy     = ($urandom_range(0, 6) == 0);
            rst          = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;
        nops(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
